// File: rtl/led_drv_pkg.sv
// Shared types and constants for the multi-channel LED driver.
package led_drv_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_ON     = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_STROBE = 2'd3
   } mode_e;

   localparam int TICK_DIV_DEFAULT = 50000;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode/period, counts prescaler ticks and decodes the lit state.
module led_channel
   import led_drv_pkg::*;
#(
   parameter int PER_W = 16
) (
   input  logic             Clk50M,
   input  logic             Rst,
   input  logic             tick,
   input  logic             we,
   input  mode_e            mode,
   input  logic [PER_W-1:0] period,
   output logic             lit
);

   mode_e            mode_q;
   logic [PER_W-1:0] period_q;
   logic [PER_W-1:0] pcnt;
   logic             phase;

   // A write on the same cycle as a tick takes precedence and restarts the count.
   always_ff @(posedge Clk50M) begin
      if (Rst) begin
         mode_q   <= MODE_OFF;
         period_q <= PER_W'(1);
         pcnt     <= '0;
         phase    <= 1'b0;
      end else if (we) begin
         mode_q   <= mode;
         period_q <= (period == '0) ? PER_W'(1) : period;
         pcnt     <= '0;
         phase    <= 1'b0;
      end else if (tick) begin
         if (pcnt == period_q - PER_W'(1)) begin
            pcnt  <= '0;
            phase <= ~phase;
         end else begin
            pcnt <= pcnt + PER_W'(1);
         end
      end
   end

   always_comb begin
      lit = 1'b0;
      case (mode_q)
         MODE_OFF:    lit = 1'b0;
         MODE_ON:     lit = 1'b1;
         MODE_BLINK:  lit = ~phase;
         MODE_STROBE: lit = (pcnt == '0);
         default:     lit = 1'b0;
      endcase
   end

endmodule

// File: rtl/led_bank_driver.sv
// Multi-channel LED driver: shared tick prescaler, per-channel pattern engines,
// global PWM brightness gate and registered LED pins.
module led_bank_driver
   import led_drv_pkg::*;
#(
   parameter int   CH             = 8,
   parameter int   TICK_DIV       = TICK_DIV_DEFAULT,
   parameter int   PER_W          = 16,
   parameter int   PWM_W          = 4,
   parameter bit   LED_ACTIVE_LOW = 1'b1,
   localparam int  CH_W           = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             Clk50M,
   input  logic             Rst,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [PER_W-1:0] cfg_period,
   output logic             cfg_ack,
   input  logic [PWM_W-1:0] bright,
   output logic             tick_o,
   output logic [CH-1:0]    FPGA_LED
);

   localparam int TD_W = $clog2(TICK_DIV);
   localparam logic [TD_W-1:0]  PRESC_LAST = TD_W'(TICK_DIV - 1);
   localparam logic [TD_W-1:0]  PRESC_PRE  = TD_W'(TICK_DIV - 2);
   localparam logic [PWM_W-1:0] PWM_LAST   = ~PWM_W'(1);

   logic [TD_W-1:0]  presc;
   logic [PWM_W-1:0] pwm_cnt;
   logic             gate;
   logic             ch_ok;
   logic [CH-1:0]    we_ch;
   logic [CH-1:0]    lit;

   assign ch_ok = int'(cfg_ch) < CH;
   assign gate  = pwm_cnt < bright;

   // tick_o is registered one cycle early so it is high exactly while presc sits at its last count.
   always_ff @(posedge Clk50M) begin
      if (Rst) begin
         presc    <= '0;
         tick_o   <= 1'b0;
         pwm_cnt  <= '0;
         cfg_ack  <= 1'b0;
         FPGA_LED <= {CH{LED_ACTIVE_LOW}};
      end else begin
         presc    <= (presc == PRESC_LAST) ? '0 : presc + TD_W'(1);
         tick_o   <= (presc == PRESC_PRE);
         pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
         cfg_ack  <= cfg_we && ch_ok;
         FPGA_LED <= (lit & {CH{gate}}) ^ {CH{LED_ACTIVE_LOW}};
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      assign we_ch[i] = cfg_we && (int'(cfg_ch) == i);

      led_channel #(
         .PER_W (PER_W)
      ) u_ch (
         .Clk50M (Clk50M),
         .Rst    (Rst),
         .tick   (tick_o),
         .we     (we_ch[i]),
         .mode   (mode_e'(cfg_mode)),
         .period (cfg_period),
         .lit    (lit[i])
      );
   end

endmodule
